regfile_sb: RTL

- Parametrised integer register file with NRP combinational read ports, one write port, optional write-to-read bypass, and a per-register pending-write scoreboard.
- Sits between decode/issue and writeback in the npc core.
- Issue marks a destination pending through a valid/ready handshake; writeback writes data and retires one pending count.
- Read ports return both data and a busy flag, so issue can stall on RAW hazards.

---
 rtl/regfile_sb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write-to-read bypass and per-register pending-write scoreboard
module regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int NRP    = 2,
    parameter int CW     = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                set_valid,
    input  logic [AW-1:0]       set_addr,
    output logic                set_ready,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                flush,
    output logic                any_busy,
    output logic                sb_err
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] rf_q  [NREG];
    logic [XLEN-1:0] rf_d  [NREG];
    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            sb_err_q;
    logic            sb_err_d;

    logic            w_en;
    logic            w_cnt_zero;
    logic            set_fire;

    // Register 0 is never written, so its storage and counter stay zero.
    assign w_en       = we && (waddr != '0);
    assign w_cnt_zero = (cnt_q[waddr] == '0);
    assign set_fire   = set_valid && set_ready && (set_addr != '0);

    // A same-cycle retire frees a slot, so a saturated counter can still accept.
    always_comb begin
        set_ready = (cnt_q[set_addr] != CNT_MAX) || (we && (waddr == set_addr));
    end

    always_comb begin
        logic inc;
        logic dec;
        rf_d     = rf_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        inc      = 1'b0;
        dec      = 1'b0;

        if (w_en) begin
            rf_d[waddr] = wdata;
        end

        if (w_en && w_cnt_zero) begin
            sb_err_d = 1'b1;
        end

        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = set_fire && (set_addr == AW'(r));
            dec = w_en && (waddr == AW'(r)) && (cnt_q[r] != '0);
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r]  <= rf_d[r];
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    // Read ports; forwarding is masked during reset so outputs read as zero.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [CW-1:0]   c;
        logic            hit_w;
        logic [XLEN-1:0] rd;
        logic            busy;
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        c     = '0;
        hit_w = 1'b0;
        rd    = '0;
        busy  = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            ra    = raddr[i*AW +: AW];
            c     = cnt_q[ra];
            hit_w = w_en && (waddr == ra);
            rd    = rf_q[ra];
            busy  = (c != '0);
            if (BYPASS != 0) begin
                if (hit_w) begin
                    rd = wdata;
                end
                if (hit_w && (c != '0)) begin
                    busy = ((c - 1'b1) != '0);
                end
            end
            if (!rst) begin
                rdata[i*XLEN +: XLEN] = rd;
                rbusy[i]              = busy;
            end
        end
    end

    always_comb begin
        any_busy = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            any_busy = any_busy | (cnt_q[r] != '0);
        end
    end

    assign sb_err = sb_err_q;

endmodule
